// File: rtl/rv_regfile_if.sv
// Register-file access bundle: two combinational read ports, one write port,
// plus the scrub request/busy pair. master drives requests, slave is the register file.
interface rv_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            clr_req;
    logic            busy;

    modport master (
        output rs1_addr, rs2_addr, rd_we, rd_addr, rd_data, clr_req,
        input  rs1_data, rs2_data, busy
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_data, clr_req,
        output rs1_data, rs2_data, busy
    );
endinterface

// File: rtl/rv_regfile.sv
// RISC-V style register file with x0 hardwired to zero and a sequential scrub engine.
// Define RV_REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module rv_regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    rv_regfile_if.slave   bus
);
    localparam int unsigned   AW   = $clog2(NREG);
    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   clr_cnt;
    logic [AW-1:0]   cnt_next;
    logic            scrub_we;
    logic            wr_en;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = clr_cnt;
        scrub_we   = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                wr_en = bus.rd_we && (bus.rd_addr != '0);
                if (bus.clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                scrub_we = 1'b1;
                cnt_next = clr_cnt + AW'(1);
                if (clr_cnt == LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = CLEAR;
                cnt_next   = '0;
            end
        endcase
    end

    // The array has no reset of its own; reset only restarts the scrub walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (scrub_we) begin
                regs[clr_cnt] <= '0;
            end else if (wr_en) begin
                regs[bus.rd_addr] <= bus.rd_data;
            end
        end
    end

    always_comb begin
        rs1_val = regs[bus.rs1_addr];
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_en && (bus.rs1_addr == bus.rd_addr)) begin
            rs1_val = bus.rd_data;
        end
`endif
        if ((state == CLEAR) || (bus.rs1_addr == '0)) begin
            rs1_val = '0;
        end
    end

    always_comb begin
        rs2_val = regs[bus.rs2_addr];
`ifdef RV_REGFILE_BYPASS_EN
        if (wr_en && (bus.rs2_addr == bus.rd_addr)) begin
            rs2_val = bus.rd_data;
        end
`endif
        if ((state == CLEAR) || (bus.rs2_addr == '0)) begin
            rs2_val = '0;
        end
    end

    assign bus.rs1_data = rs1_val;
    assign bus.rs2_data = rs2_val;
    assign bus.busy     = (state == CLEAR);
endmodule
